mem_requester: RTL and testbench
================================

MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, WAIT cycles without core1_ack before timeout (1..255).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state changes on posedge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  core presents load/store.
REQ-006 req_ready  output  1  requester idle, can accept.
REQ-007 req_is_wr  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  addr_width  byte address.
REQ-009 req_wr_data  input  data_width  store data.
REQ-010 resp_valid  output  1  response available.
REQ-011 resp_ready  input  1  core consumes response.
REQ-012 resp_rd_data  output  data_width  load data; 0 for stores and errors.
REQ-013 resp_err  output  2  00 ok, 01 misaligned, 10 timeout.
REQ-014 core1_rd_req / core1_wr_req  output  1 each  single-cycle request pulse to memory controller.
REQ-015 core1_addr  output  addr_width  request address.
REQ-016 core1_wr_data  output  data_width  store data.
REQ-017 core1_rd_data  input  data_width  load data, valid in the core1_ack cycle.
REQ-018 core1_busy  input  1  controller has a request in flight.
REQ-019 core1_ack  input  1  single-cycle completion pulse.

Function
REQ-020 FSM states IDLE, ISSUE, WAIT, RESP; all outputs registered or decoded from state only.
REQ-021 IDLE: req_ready=1; on req_valid, latch is_wr/addr/wr_data; go ISSUE if addr[1:0]==0, else RESP with resp_err=01 and no memory request.
REQ-022 ISSUE: if core1_busy=1, hold with both request pulses low; else assert exactly one of core1_rd_req/core1_wr_req for exactly one cycle, then go WAIT.
REQ-023 core1_addr and core1_wr_data hold latched values from ISSUE until leaving WAIT; 0 otherwise.
REQ-024 WAIT: on core1_ack, capture core1_rd_data (loads only, else 0) into resp_rd_data, resp_err=00, go RESP.
REQ-025 RESP: resp_valid=1, data/err stable until resp_valid&resp_ready; then IDLE; back-to-back acceptance only from the following IDLE cycle.
REQ-026 core1_ack outside WAIT is ignored, with no state or output change.
REQ-027 Minimum latency: req accept edge E0, request pulse cycle E0+1, resp_valid cycle after the ack edge.
REQ-028 core1_rd_req and core1_wr_req are never high simultaneously, and never high outside ISSUE.

Reset
REQ-029 rst=1: state IDLE; req_ready=1 on the cycle after reset release; all other outputs 0; timeout counter 0.
REQ-030 Reset mid-operation abandons the transaction; a later core1_ack is ignored under REQ-026.

Configuration
REQ-031 MEM_REQUESTER_TIMEOUT_EN defined: 8-bit counter loads TIMEOUT_CYCLES on entering WAIT and decrements each WAIT cycle without ack; at 0 with no ack, go RESP with resp_err=10 and resp_rd_data=0.
REQ-032 Ack in the same cycle the counter reaches 0: ack wins, resp_err=00.
REQ-033 Without MEM_REQUESTER_TIMEOUT_EN: no counter; WAIT persists until ack; resp_err=10 never produced.

Structure
REQ-034 Shared package holds addr_width=32, data_width=32, the FSM state enum and the resp_err code enum.
REQ-035 Single module; no sub-module required.

Verification
REQ-036 Load from 0x40 (memory holds 0x12345678), controller delay 5: one-cycle core1_rd_req; resp_rd_data=0x12345678, resp_err=00.
REQ-037 Store 0xDEADBEEF to 0x80, then load from 0x80: one-cycle core1_wr_req with core1_wr_data=0xDEADBEEF; load returns 0xDEADBEEF.
REQ-038 Load from 0x42: no core1 request pulse; resp_valid the next cycle with resp_err=01.
REQ-039 resp_ready held 0 for 10 cycles after resp_valid: response stable, req_ready=0 throughout; accepted on first resp_ready=1.
REQ-040 core1_busy=1 for 4 cycles during ISSUE: no pulse until busy drops, then exactly one pulse.
REQ-041 TIMEOUT_EN, TIMEOUT_CYCLES=3, ack suppressed: resp_err=10 after 4 WAIT cycles; late ack ignored. Separately, rst asserted in WAIT: IDLE, outputs 0.

Source files
------------

// File: rtl/mem_requester_pkg.sv
// Shared types for the memory requester: bus widths, FSM state encoding and
// response error codes.
package mem_requester_pkg;

  localparam int addr_width = 32;
  localparam int data_width = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK         = 2'b00,
    ERR_MISALIGNED = 2'b01,
    ERR_TIMEOUT    = 2'b10
  } resp_err_e;

endpackage

// File: rtl/mem_requester.sv
// Single-outstanding load/store requester bridging a core to a pulse-based memory
// controller. Optional WAIT timeout is enabled by defining MEM_REQUESTER_TIMEOUT_EN.
module mem_requester
  import mem_requester_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_wr,
  input  logic [addr_width-1:0] req_addr,
  input  logic [data_width-1:0] req_wr_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [data_width-1:0] resp_rd_data,
  output logic [1:0]            resp_err,
  output logic                  core1_rd_req,
  output logic                  core1_wr_req,
  output logic [addr_width-1:0] core1_addr,
  output logic [data_width-1:0] core1_wr_data,
  input  logic [data_width-1:0] core1_rd_data,
  input  logic                  core1_busy,
  input  logic                  core1_ack
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ISSUE = ST_ISSUE;
  localparam logic [1:0] S_WAIT  = ST_WAIT;
  localparam logic [1:0] S_RESP  = ST_RESP;

  if (TIMEOUT_CYCLES == 32'd0 || TIMEOUT_CYCLES > 32'd255) begin : g_bad_timeout
    $error("mem_requester: TIMEOUT_CYCLES must be in 1..255");
  end

  logic [1:0]            state_r;
  logic [1:0]            state_nxt_s;
  logic                  is_wr_r;
  logic [addr_width-1:0] addr_r;
  logic [data_width-1:0] wr_data_r;
  logic [data_width-1:0] rd_data_r;
  logic [1:0]            err_r;
  logic                  tmo_hit_s;
  logic                  issue_go_s;
  logic                  in_flight_s;

  assign issue_go_s  = (state_r == S_ISSUE) && !core1_busy;
  assign in_flight_s = (state_r == S_ISSUE) || (state_r == S_WAIT);

`ifdef MEM_REQUESTER_TIMEOUT_EN
  localparam logic [7:0] tmo_load = 8'(TIMEOUT_CYCLES);
  logic [7:0] tmo_cnt_r;

  // WAIT watchdog: armed as the request leaves ISSUE, counts down while no ack
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_r <= 8'd0;
    end else if (issue_go_s) begin
      tmo_cnt_r <= tmo_load;
    end else if ((state_r == S_WAIT) && !core1_ack && (tmo_cnt_r != 8'd0)) begin
      tmo_cnt_r <= tmo_cnt_r - 8'd1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // an ack in the expiry cycle takes priority over the timeout
  assign tmo_hit_s = (state_r == S_WAIT) && !core1_ack && (tmo_cnt_r == 8'd0);
`else
  assign tmo_hit_s = 1'b0;
`endif

  // next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (req_valid) begin
          state_nxt_s = (req_addr[1:0] == 2'b00) ? S_ISSUE : S_RESP;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (!core1_busy) state_nxt_s = S_WAIT;
        else             state_nxt_s = S_ISSUE;
      end
      S_WAIT: begin
        if (core1_ack || tmo_hit_s) state_nxt_s = S_RESP;
        else                        state_nxt_s = S_WAIT;
      end
      S_RESP: begin
        if (resp_ready) state_nxt_s = S_IDLE;
        else            state_nxt_s = S_RESP;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // state, request latch and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      is_wr_r   <= 1'b0;
      addr_r    <= '0;
      wr_data_r <= '0;
      rd_data_r <= '0;
      err_r     <= ERR_OK;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        S_IDLE: begin
          if (req_valid) begin
            is_wr_r   <= req_is_wr;
            addr_r    <= req_addr;
            wr_data_r <= req_wr_data;
            rd_data_r <= '0;
            err_r     <= (req_addr[1:0] == 2'b00) ? ERR_OK : ERR_MISALIGNED;
          end
        end
        S_WAIT: begin
          if (core1_ack) begin
            rd_data_r <= is_wr_r ? '0 : core1_rd_data;
            err_r     <= ERR_OK;
          end else if (tmo_hit_s) begin
            rd_data_r <= '0;
            err_r     <= ERR_TIMEOUT;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            rd_data_r <= '0;
            err_r     <= ERR_OK;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_ready     = (state_r == S_IDLE);
  assign resp_valid    = (state_r == S_RESP);
  assign resp_rd_data  = rd_data_r;
  assign resp_err      = err_r;
  // the pulse must drop in the same cycle the controller reports busy
  assign core1_rd_req  = issue_go_s && !is_wr_r;
  assign core1_wr_req  = issue_go_s && is_wr_r;
  assign core1_addr    = in_flight_s ? addr_r : '0;
  assign core1_wr_data = in_flight_s ? wr_data_r : '0;

endmodule

// File: tb/tb_mem_requester.sv
// Scoreboard bench for mem_requester: a behavioural memory/controller model answers
// request pulses; a monitor checks responses against expectations queued at issue.
module tb_mem_requester;
  import mem_requester_pkg::*;

  localparam int TB_TIMEOUT = 3;
`ifdef MEM_REQUESTER_TIMEOUT_EN
  localparam bit tmo_en = 1'b1;
`else
  localparam bit tmo_en = 1'b0;
`endif

  logic        clk, rst;
  logic        req_valid, req_ready, req_is_wr;
  logic [31:0] req_addr, req_wr_data;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rd_data;
  logic [1:0]  resp_err;
  logic        core1_rd_req, core1_wr_req, core1_busy, core1_ack;
  logic [31:0] core1_addr, core1_wr_data, core1_rd_data;

  mem_requester #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_wr(req_is_wr),
    .req_addr(req_addr), .req_wr_data(req_wr_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rd_data(resp_rd_data), .resp_err(resp_err),
    .core1_rd_req(core1_rd_req), .core1_wr_req(core1_wr_req),
    .core1_addr(core1_addr), .core1_wr_data(core1_wr_data),
    .core1_rd_data(core1_rd_data), .core1_busy(core1_busy), .core1_ack(core1_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] data; logic [1:0] err; } resp_t;
  typedef struct packed { logic wr; logic [31:0] addr; logic [31:0] data; } iss_t;

  resp_t       exp_q[$];
  iss_t        iss_q[$];
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] ctrl_mem [logic [31:0]];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int ack_delay = 0;
  bit tb_pend = 1'b0;
  int pulse_count = 0;
  int pulse_cyc = 0;
  int rise_cyc = 0;
  int acc_cyc = 0;
  bit busy_force = 1'b0;
  bit busy_rand = 1'b0;
  int ready_mode = 2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_lat(input int d);
    return (tmo_en && d > TB_TIMEOUT) ? TB_TIMEOUT + 2 : d + 2;
  endfunction

  // controller model: sees pulses, stores writes, acks after ack_delay cycles
  initial begin
    int cnt; bit pwr; logic [31:0] paddr; iss_t e;
    cnt = 0; pwr = 1'b0; paddr = 32'd0;
    core1_ack = 1'b0; core1_busy = 1'b0; core1_rd_data = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst && (core1_rd_req || core1_wr_req)) begin
        check("req_exclusive", 32'(core1_rd_req & core1_wr_req), 32'd0);
        check("pulse_while_busy", 32'(core1_busy), 32'd0);
        pulse_count++;
        pulse_cyc = cyc;
        if (iss_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_pulse: actual pulse at cycle %0d required none", cyc);
        end else begin
          e = iss_q.pop_front();
          check("pulse_kind", 32'(core1_wr_req), 32'(e.wr));
          check("core1_addr", core1_addr, e.addr);
          if (e.wr) check("core1_wr_data", core1_wr_data, e.data);
        end
        pwr = core1_wr_req; paddr = core1_addr;
        if (core1_wr_req) ctrl_mem[core1_addr] = core1_wr_data;
        cnt = ack_delay; tb_pend = 1'b1;
      end
      @(posedge clk); #1;
      core1_ack = 1'b0;
      core1_rd_data = $urandom;
      if (tb_pend) begin
        if (cnt == 0) begin
          core1_ack = 1'b1;
          core1_rd_data = pwr ? $urandom : (ctrl_mem.exists(paddr) ? ctrl_mem[paddr] : 32'd0);
          tb_pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      core1_busy = busy_force || (busy_rand && ($urandom_range(0, 7) == 0));
    end
  end

  // response back-pressure
  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        1:       resp_ready = 1'b0;
        2:       resp_ready = 1'b1;
        default: resp_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // monitor: response hold while stalled, scoreboard compare on handshake
  initial begin
    resp_t e; bit pv; bit pr; logic [31:0] pd; logic [1:0] pe;
    pv = 1'b0; pr = 1'b0; pd = 32'd0; pe = 2'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          check("resp_hold_valid", 32'(resp_valid), 32'd1);
          check("resp_hold_data", resp_rd_data, pd);
          check("resp_hold_err", 32'(resp_err), 32'(pe));
        end
        if (resp_valid && !pv) rise_cyc = cyc;
        if (resp_valid) begin
          check("req_ready_in_resp", 32'(req_ready), 32'd0);
          if (resp_ready) begin
            if (exp_q.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL spurious_resp: actual resp data 0x%0h err %0d required none", resp_rd_data, resp_err);
            end else begin
              e = exp_q.pop_front();
              check("resp_rd_data", resp_rd_data, e.data);
              check("resp_err", 32'(resp_err), 32'(e.err));
            end
          end
        end
        pv = resp_valid; pr = resp_ready; pd = resp_rd_data; pe = resp_err;
      end
    end
  end

  // issue one request (called at posedge+#1) and queue its expected outcome
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] data, input int delay);
    int g; resp_t r; iss_t s;
    g = 0;
    while (!(req_ready && !tb_pend) && g < 300) begin @(posedge clk); #1; g++; end
    if (g >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL req_ready_wait: actual not ready after %0d cycles required ready", g);
    end
    req_valid = 1'b1; req_is_wr = wr; req_addr = addr; req_wr_data = data;
    ack_delay = delay; acc_cyc = cyc;
    if (addr[1:0] != 2'b00) begin
      r.data = 32'd0; r.err = 2'b01;
    end else begin
      s.wr = wr; s.addr = addr; s.data = data;
      iss_q.push_back(s);
      if (wr) ref_mem[addr] = data;
      if (tmo_en && delay > TB_TIMEOUT) begin
        r.data = 32'd0; r.err = 2'b10;
      end else begin
        r.err = 2'b00;
        r.data = wr ? 32'd0 : (ref_mem.exists(addr) ? ref_mem[addr] : 32'd0);
      end
    end
    exp_q.push_back(r);
    @(posedge clk); #1;
    req_valid = 1'b0; req_is_wr = 1'($urandom); req_addr = $urandom; req_wr_data = $urandom;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || tb_pend || !req_ready) && g < 400) begin @(posedge clk); #1; g++; end
    if (g >= 400) begin
      n_checks++; n_fail++;
      $display("FAIL drain: actual %0d responses outstanding required 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual time limit reached required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc0, g;
    logic [31:0] addr;
    rst = 1'b1; req_valid = 1'b0; req_is_wr = 1'b0; req_addr = 32'd0; req_wr_data = 32'd0;
    ref_mem[32'h40] = 32'h12345678; ctrl_mem[32'h40] = 32'h12345678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rd_data", resp_rd_data, 32'd0);
    check("rst_core1_req", 32'({core1_rd_req, core1_wr_req}), 32'd0);
    check("rst_core1_addr", core1_addr, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("req_ready_after_reset", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // load 0x40 with controller delay 5
    do_req(1'b0, 32'h40, 32'd0, 5); drain();
    check("load_pulse_latency", 32'(pulse_cyc - acc_cyc), 32'd1);
    check("load_resp_latency", 32'(rise_cyc - pulse_cyc), 32'(exp_lat(5)));

    // store then load back
    do_req(1'b1, 32'h80, 32'hDEADBEEF, 2); drain();
    do_req(1'b0, 32'h80, 32'd0, 1); drain();
    check("reload_latency", 32'(rise_cyc - pulse_cyc), 32'(exp_lat(1)));

    // misaligned: no pulse, response next cycle
    pc0 = pulse_count;
    do_req(1'b0, 32'h42, 32'd0, 0); drain();
    check("misaligned_no_pulse", 32'(pulse_count - pc0), 32'd0);
    check("misaligned_latency", 32'(rise_cyc - acc_cyc), 32'd1);

    // ack exactly at counter expiry, and beyond it (timeout when enabled)
    do_req(1'b0, 32'h40, 32'd0, TB_TIMEOUT); drain();
    check("edge_ack_latency", 32'(rise_cyc - pulse_cyc), 32'(exp_lat(TB_TIMEOUT)));
    do_req(1'b0, 32'h40, 32'd0, 8); drain();
    check("late_ack_latency", 32'(rise_cyc - pulse_cyc), 32'(exp_lat(8)));

    // hold resp_ready low for 10 cycles
    ready_mode = 1;
    do_req(1'b0, 32'h80, 32'd0, 0);
    g = 0;
    while (!resp_valid && g < 100) begin @(negedge clk); g++; end
    check("stall_resp_seen", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(resp_valid), 32'd1);
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    ready_mode = 2;
    @(negedge clk);
    check("stall_accept", 32'({resp_valid, resp_ready}), 32'd3);
    @(negedge clk);
    check("stall_released", 32'({resp_valid, req_ready}), 32'd1);
    @(posedge clk); #1;

    // controller busy for 4 ISSUE cycles
    busy_force = 1'b1;
    @(posedge clk); #1;
    pc0 = pulse_count;
    do_req(1'b1, 32'hC0, 32'hCAFE0001, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_no_pulse", 32'({core1_rd_req, core1_wr_req}), 32'd0);
    end
    busy_force = 1'b0;
    @(posedge clk); #1;
    drain();
    check("busy_one_pulse", 32'(pulse_count - pc0), 32'd1);

    // reset during WAIT abandons the transaction; the late ack is ignored
    do_req(1'b0, 32'h40, 32'd0, 4);
    @(posedge clk); #1;
    rst = 1'b1; exp_q.delete(); iss_q.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    check("midrst_core1_addr", core1_addr, 32'd0);
    check("midrst_outputs", 32'({core1_rd_req, core1_wr_req, resp_err}), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("midrst_late_ack_ignored", 32'({resp_valid, req_ready}), 32'd1);
    end
    @(posedge clk); #1;

    // randomized traffic
    busy_rand = 1'b1; ready_mode = 0;
    for (int i = 0; i < 80; i++) begin
      addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 5) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      do_req(1'($urandom), addr, $urandom, int'($urandom_range(0, 4)));
    end
    drain();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
